fnd_scan_controller: RTL

//   Time-multiplexed scan source for the 4-digit FND. Divides the system clock to a scan tick, steps a
//   3-bit digit position 0..7 (fed straight to the 3x4 digit decoder), and drives the active-low segment

---
 rtl/fnd_scan_controller.sv | 91 +++++++++
 1 files changed

// File: rtl/fnd_scan_controller.sv
// Scan source for a 4-digit FND. It steps 8 scan positions: 4 BCD digits, then 4 decimal points.
// Input data is latched once per frame so a frame never shows a mix of old and new values.
module fnd_scan_controller #(
  parameter int SCAN_DIV     = 100_000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dotMask,
  input  logic        i_blinkEn,
  output logic [2:0]  o_digitPosition,
  output logic [7:0]  o_fndFont,
  output logic        o_frameStart
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = $clog2(BLINK_FRAMES) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_pos;
  logic [15:0]      r_bcd;
  logic [3:0]       r_mask;
  logic [FRM_W-1:0] r_frame;
  logic             r_phase;
  logic             r_frame_start;
  logic             tick;
  logic             frame_edge;
  logic [3:0]       digit_nib;

  assign tick       = (r_div == DIV_LAST);
  assign frame_edge = tick && (r_pos == 3'd7);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div         <= '0;
      r_pos         <= 3'd0;
      r_bcd         <= 16'h0000;
      r_mask        <= 4'h0;
      r_frame       <= '0;
      r_phase       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= tick ? '0 : r_div + 1'b1;
      r_frame_start <= frame_edge;
      if (tick) r_pos <= r_pos + 3'd1;
      // The blink counter runs whether or not blinking is enabled, so enabling it mid-run
      // joins the existing phase instead of restarting it.
      if (frame_edge) begin
        r_bcd  <= i_bcd;
        r_mask <= i_dotMask;
        if (r_frame == FRM_LAST) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end
    end
  end

  assign digit_nib = r_bcd[{r_pos[1:0], 2'b00} +: 4];

  always_comb begin
    o_fndFont = 8'hFF;
    if (!r_pos[2]) begin
      case (digit_nib)
        4'd0:    o_fndFont = 8'hC0;
        4'd1:    o_fndFont = 8'hF9;
        4'd2:    o_fndFont = 8'hA4;
        4'd3:    o_fndFont = 8'hB0;
        4'd4:    o_fndFont = 8'h99;
        4'd5:    o_fndFont = 8'h92;
        4'd6:    o_fndFont = 8'h82;
        4'd7:    o_fndFont = 8'hF8;
        4'd8:    o_fndFont = 8'h80;
        4'd9:    o_fndFont = 8'h90;
        default: o_fndFont = 8'hFF;
      endcase
    end else begin
      // The blink enable is taken live, so it acts immediately rather than at the next frame.
      o_fndFont = {~(r_mask[r_pos[1:0]] & (~i_blinkEn | r_phase)), 7'h7F};
    end
  end

  assign o_digitPosition = r_pos;
  assign o_frameStart    = r_frame_start;

endmodule
